snake_uart_tx: RTL
==================

// Module: snake_uart_tx
// PURPOSE
//  Transmit side of the host UART link used by the snake game (host -> board keys use the RX path).
//  Accepts bytes from game logic (score, game-over, echo), buffers them in a small FIFO and
//  serialises them as 8N1 frames on TX. Runs in the 25 MHz clk domain, alongside the RX edge detector.
// PARAMETERS
//  CLK_FREQ    25_000_000  clk frequency in Hz
//  BAUD        115200      line rate; DIV = CLK_FREQ/BAUD, integer-truncated (217 at defaults)
//  FIFO_DEPTH  4           byte FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk       in   1  25 MHz system clock
//  rstn      in   1  synchronous, active-low reset
//  dataTX    in   8  byte to send; sampled only when WR_TX = 1
//  WR_TX     in   1  one-cycle write strobe; level, not edge-detected
//  TX        out  1  serial line, registered, idles high
//  full      out  1  FIFO holds FIFO_DEPTH bytes; writes are dropped while high
//  busy      out  1  FSM not in IDLE, or FIFO not empty
//  overflow  out  1  sticky: a write arrived while full; cleared only by reset
// BEHAVIOUR
//  - Reset (rstn = 0 at a clk edge): TX = 1, full = 0, busy = 0, overflow = 0.
//    FIFO is emptied, FSM goes to IDLE, baud counter = 0. Applies mid-frame: TX is high after that edge.
//  - Write: at edge N with WR_TX = 1 and full = 0, dataTX is pushed. The FIFO count is visible at N+1.
//    With full = 1 the byte is discarded and overflow is set. There is no pass-through when a pop
//    happens in the same cycle.
//  - FSM states: IDLE, START, DATA, STOP. A single baud counter runs 0..DIV-1; a bit index runs 0..7.
//      IDLE : TX = 1. When FIFO is non-empty, pop into shift register -> START.
//             Write at edge N into an empty idle block gives TX = 0 after edge N+2.
//      START: TX = 0 for exactly DIV cycles -> DATA with bit index 0.
//      DATA : TX = shift[0], LSB first. Each bit lasts exactly DIV cycles. Shift right at bit end.
//             After bit 7 -> STOP.
//      STOP : TX = 1 for exactly DIV cycles. On the last stop cycle: if the FIFO is non-empty,
//             pop and go directly to START with zero idle cycles between frames; else go to IDLE.
//  - Frame length is exactly 10*DIV cycles. Back-to-back bytes produce contiguous frames.
//  - Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
//    Pop on empty never happens.
//  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
//    full = (count == FIFO_DEPTH).
//  - Baud counter width is $clog2(DIV). DIV < 2 is illegal; flag it with an elaboration-time check.
//  - busy falls after the edge that ends the last stop bit when the FIFO is empty.
// STRUCTURE
//  - Shared include snake_uart_defs.vh holds:
//      FSM state encodings (IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3);
//      default CLK_FREQ and BAUD, shared with the RX path.
//  - One sub-module, byte_fifo: synchronous FIFO, parameters DEPTH and WIDTH = 8.
//    Ports: clk, rstn, wr, din, rd, dout, full, empty. dout is valid in the same cycle as rd (first-word fall-through).
//  - The top level holds the FSM, baud counter, shift register, TX register and overflow flag.
// TESTING
//  1. Hold rstn = 0 for 3 cycles -> TX = 1, busy = 0, full = 0, overflow = 0. TX stays 1 for 5000 idle cycles.
//  2. Defaults; WR_TX with 0x41 at edge N -> TX = 0 after N+2, then bits 1,0,0,0,0,0,1,0 each
//     exactly 217 cycles, then stop = 1 for 217 cycles. busy = 0 after 2170 cycles of frame.
//  3. Write 0x10..0x15 on 6 consecutive cycles -> 0x10 popped at once, full = 1 after the 5th write,
//     0x15 dropped, overflow = 1. Exactly 5 contiguous frames 0x10..0x14 with no idle gap.
//  4. Pulse rstn = 0 during DATA bit 3 of 0xA5 -> TX = 1 on the next edge, busy = 0, FIFO empty.
//     No further start bit appears.
//  5. BAUD = CLK_FREQ/4 (DIV = 4); write 0x00 then 0xFF -> 80-cycle waveform:
//     0 x36 then 1 x4, then 0 x4, 1 x32, 1 x4, checked against a reference model.
//  6. Random writes throttled by full over 10k frames -> the receiver model decodes an identical byte
//     sequence and overflow stays 0.

Source files
------------

// File: rtl/snake_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// snake_uart_tx_pkg
// Types and defaults shared by the snake UART transmit path.
//   state_e           : transmit FSM state encoding (IDLE/START/DATA/STOP)
//   DEFAULT_CLK_FREQ  : system clock frequency in Hz, shared with the RX path
//   DEFAULT_BAUD      : line rate, shared with the RX path
//   calc_div()        : clocks per bit, integer-truncated
// ---------------------------------------------------------------------------
package snake_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam int DEFAULT_CLK_FREQ = 25_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/snake_uart_tx_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous first-word-fall-through FIFO.
//   clk   in   clock
//   rstn  in   synchronous active-low reset (empties the FIFO)
//   wr    in   push din; ignored while full
//   din   in   WIDTH-bit write data
//   rd    in   pop; dout already holds the head entry in this cycle
//   dout  out  head entry (valid while !empty)
//   full  out  DEPTH entries held
//   empty out  no entries held
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("byte_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign push  = wr && !full;
    assign pop   = rd && !empty;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/snake_uart_tx.sv
// ---------------------------------------------------------------------------
// snake_uart_tx
// Buffers bytes from the game logic and sends them as 8N1 frames, LSB first.
//   clk       in   system clock
//   rstn      in   synchronous active-low reset
//   dataTX    in   byte to send, sampled when WR_TX = 1
//   WR_TX     in   write strobe, one byte per high cycle
//   TX        out  registered serial line, idles high
//   full      out  FIFO full; writes are dropped while high
//   busy      out  frame in progress or bytes waiting
//   overflow  out  sticky: a write arrived while full (cleared by reset)
// ---------------------------------------------------------------------------
module snake_uart_tx
    import snake_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] dataTX,
    input  logic       WR_TX,
    output logic       TX,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("snake_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          fifo_rd;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          bit_end;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (WR_TX),
        .din   (dataTX),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_rd    = 1'b0;
        overflow_d = overflow_q | (WR_TX & full);

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_dout;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_d = bit_end ? '0 : baud_q + 1'b1;
                // Chain straight into the next start bit when data is waiting.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line register follows the current state, so the line trails the
    // FSM by one cycle; every bit still lasts exactly DIV cycles.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign TX       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule
